// File: rtl/seq_addsub.sv
// Multi-cycle signed adder/subtractor: CHUNK bits per clock through a registered carry,
// with a valid/ready handshake on both sides and registered ALU status flags.
module seq_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] slice_ext;
    logic             last;

    // Operands shift right each cycle, so the active chunk always sits in the low bits;
    // the sum slice enters the result from the top and reaches its place after NCH steps.
    assign sum       = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(c_q);
    assign slice_ext = WIDTH'(sum[CHUNK-1:0]);
    assign last      = (k_q == KW'(NCH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            dout_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            k_q     <= k_d;
            dout_q  <= dout_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        k_d     = k_q;
        dout_d  = dout_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = data_A;
                    b_d     = data_B ^ {WIDTH{sub}};
                    c_d     = sub;
                    k_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                c_d   = sum[CHUNK];
                res_d = (res_q >> CHUNK) | (slice_ext << (WIDTH - CHUNK));
                k_d   = k_q + 1'b1;
                if (last) begin
                    // Same-sign operands giving an opposite-sign result is carry-in(MSB) ^ carry-out(MSB).
                    state_d = S_DONE;
                    k_d     = '0;
                    dout_d  = res_d;
                    carry_d = sum[CHUNK];
                    ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (sum[CHUNK-1] != a_q[CHUNK-1]);
                    zero_d  = ~|res_d;
                    neg_d   = res_d[WIDTH-1];
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign data_out  = dout_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Bench for seq_addsub: directed table, handshake/reset sequences, random ops against an
// arithmetic reference model, and a 16-bit sweep at CHUNK=16 and CHUNK=4.
module tb_seq_addsub;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] data_A, data_B, data_out;
    logic        carry, overflow, zero, negative;

    logic        in_valid16, sub16, out_ready16;
    logic [15:0] a16, b16;
    logic        in_ready_x, out_valid_x, c_x, v_x, z_x, n_x;
    logic [15:0] dout_x;
    logic        in_ready_y, out_valid_y, c_y, v_y, z_y, n_y;
    logic [15:0] dout_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_A(data_A), .data_B(data_B), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .carry(carry),
        .overflow(overflow), .zero(zero), .negative(negative)
    );

    seq_addsub #(.WIDTH(16), .CHUNK(16)) u_x (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready_x),
        .data_A(a16), .data_B(b16), .sub(sub16), .out_valid(out_valid_x),
        .out_ready(out_ready16), .data_out(dout_x), .carry(c_x),
        .overflow(v_x), .zero(z_x), .negative(n_x)
    );

    seq_addsub #(.WIDTH(16), .CHUNK(4)) u_y (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready_y),
        .data_A(a16), .data_B(b16), .sub(sub16), .out_valid(out_valid_y),
        .out_ready(out_ready16), .data_out(dout_y), .carry(c_y),
        .overflow(v_y), .zero(z_y), .negative(n_y)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp;
        logic [3:0]  flags;  // {carry, overflow, zero, negative}
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned interpretation of plain integer arithmetic.
    function automatic void model(input int w, input longint a_u, input longint b_u, input bit s,
                                  output longint r, output logic [3:0] f);
        longint m, half, as, bs, rs, ru;
        bit c, v;
        m    = longint'(1) << w;
        half = m >> 1;
        as   = (a_u >= half) ? a_u - m : a_u;
        bs   = (b_u >= half) ? b_u - m : b_u;
        rs   = s ? as - bs : as + bs;
        ru   = s ? a_u - b_u : a_u + b_u;
        v    = (rs >= half) || (rs < -half);
        c    = s ? (a_u >= b_u) : (ru >= m);
        r    = ((ru % m) + m) % m;
        f    = {c, v, (r == 0), (r >= half)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
        chk("in_ready_before_accept", in_ready, 1'b1);
        data_A   = a;
        data_B   = b;
        sub      = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", out_valid, 1'b1);
    endtask

    task automatic release32();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_release", out_valid, 1'b0);
        chk("in_ready_after_release", in_ready, 1'b1);
    endtask

    vec_t        tbl[6];
    int          lat;
    logic [31:0] held;
    longint      r;
    logic [3:0]  f;
    int          seen;

    initial begin
        tbl[0] = '{32'd1234, 32'hFFFF_FDC9, 1'b0, 32'd667, 4'b1000};         // 1234 + (-567)
        tbl[1] = '{32'd100, 32'd300, 1'b1, 32'hFFFF_FF38, 4'b0001};
        tbl[2] = '{32'd5, 32'd5, 1'b1, 32'h0000_0000, 4'b1010};
        tbl[3] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 4'b0101};
        tbl[4] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 4'b1010};
        tbl[5] = '{32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 4'b1100};      // most negative - 1

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
        data_A = '0; data_B = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b1; sub16 = 1'b0; a16 = '0; b16 = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_flags", {carry, overflow, zero, negative}, 4'b0000);

        for (int i = 0; i < 6; i++) begin
            op32(tbl[i].a, tbl[i].b, tbl[i].sub, lat);
            chk("table_latency", lat, 4);
            chk("table_data_out", data_out, tbl[i].exp);
            chk("table_flags", {carry, overflow, zero, negative}, tbl[i].flags);
            release32();
        end

        // Back-pressure and ignored in_valid during CALC/DONE.
        data_A = 32'h1111_1111; data_B = 32'h2222_2222; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("in_ready_calc", in_ready, 1'b0);
        data_A = 32'hDEAD_BEEF; data_B = 32'h0BAD_F00D; sub = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("out_valid_calc", out_valid, 1'b0);
        tick();
        chk("hs_out_valid", out_valid, 1'b1);
        chk("hs_data_out", data_out, 32'h3333_3333);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_out_valid", out_valid, 1'b1);
            chk("hold_data_out", data_out, 32'h3333_3333);
        end
        in_valid = 1'b0;
        release32();
        tick(); tick();
        chk("idle_no_spurious_op", out_valid, 1'b0);
        chk("idle_retains_data_out", data_out, 32'h3333_3333);

        // Reset one cycle after accept aborts the operation.
        data_A = 32'd40; data_B = 32'd2; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_data_out", data_out, 32'd0);
        chk("abort_flags", {carry, overflow, zero, negative}, 4'b0000);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);

        // Random 32-bit operations with random consumer delay.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = $urandom;
            b = (i % 5 == 0) ? a : $urandom;
            s = $urandom_range(1);
            model(32, longint'(a), longint'(b), s, r, f);
            op32(a, b, s, lat);
            chk("rand_latency", lat, 4);
            held = data_out;
            chk("rand_data_out", data_out, r[31:0]);
            chk("rand_flags", {carry, overflow, zero, negative}, f);
            for (int j = 0; j < int'($urandom_range(3)); j++) begin
                tick();
                chk("rand_hold", {out_valid, data_out}, {1'b1, held});
            end
            release32();
        end

        // 16-bit sweep, both chunkings fed the same operands.
        for (int i = 0; i < 400; i++) begin
            int          av, bv, lx, ly;
            logic [19:0] rx, ry;
            av = int'($urandom_range(1998)) - 999;
            bv = int'($urandom_range(1998)) - 999;
            a16 = av[15:0];
            b16 = bv[15:0];
            sub16 = i[0];
            model(16, longint'(a16), longint'(b16), sub16, r, f);
            in_valid16 = 1'b1;
            tick();
            in_valid16 = 1'b0;
            lx = 0; ly = 0; rx = '0; ry = '0;
            for (int cyc = 1; cyc <= 8; cyc++) begin
                tick();
                if (out_valid_x && lx == 0) begin
                    lx = cyc;
                    rx = {dout_x, c_x, v_x, z_x, n_x};
                end
                if (out_valid_y && ly == 0) begin
                    ly = cyc;
                    ry = {dout_y, c_y, v_y, z_y, n_y};
                end
            end
            chk("w16c16_latency", lx, 1);
            chk("w16c4_latency", ly, 4);
            chk("w16c16_result", rx, {r[15:0], f});
            chk("w16c4_result", ry, {r[15:0], f});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
